// File: rtl/aximm_stream_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aximm_stream_pkg
// Purpose  : Packet layout shared by aximm_over_stream_client and
//            aximm_over_stream_server. One packet is one 256-bit AXIS beat
//            made of 32-bit fields: TYPE, ADRL, ADRH, DATA, RESP.
// Contents : packet type codes, field LSB indices, stream width, pack_pkt().
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package aximm_stream_pkg;

   localparam int AXIS_W = 256;

   localparam logic [31:0] PKT_TYPE_READ  = 32'd1;
   localparam logic [31:0] PKT_TYPE_WRITE = 32'd2;

   // LSB of each 32-bit field inside the beat
   localparam int PF_TYPE = 0;
   localparam int PF_ADRL = 32;
   localparam int PF_ADRH = 64;
   localparam int PF_DATA = 96;
   localparam int PF_RESP = 128;

   // Build a beat; every bit outside the five fields is zero.
   function automatic logic [AXIS_W-1:0] pack_pkt(
      input logic [31:0] ptype,
      input logic [63:0] addr,
      input logic [31:0] data,
      input logic [31:0] resp
   );
      logic [AXIS_W-1:0] pkt;
      pkt                 = '0;
      pkt[PF_TYPE +: 32]  = ptype;
      pkt[PF_ADRL +: 32]  = addr[31:0];
      pkt[PF_ADRH +: 32]  = addr[63:32];
      pkt[PF_DATA +: 32]  = data;
      pkt[PF_RESP +: 32]  = resp;
      return pkt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aximm_over_stream_client.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aximm_over_stream_client
// Purpose  : AXI4-Lite slave that tunnels each accepted read/write as one
//            request beat on AXIS_TX and completes it from the matching
//            response beat on AXIS_RX. One transaction outstanding at a time.
// Ports    : clk, resetn (synchronous, active-low)
//            S_AXI_*    AXI4-Lite slave (AW/W/B/AR/R); PROT and WSTRB ignored
//            AXIS_TX_*  request stream (one beat per transaction, TLAST=1)
//            AXIS_RX_*  response stream (TLAST ignored)
// Config   : AOS_CLIENT_TIMEOUT_EN - when defined, a response not seen within
//            TIMEOUT_CYCLES completes the transaction with SLVERR and
//            RDATA=32'hDEAD_DEAD. When undefined the client waits forever.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module aximm_over_stream_client
   import aximm_stream_pkg::*;
#(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 32,
   parameter int AXIS_DATA_WIDTH = 256,
   parameter int TIMEOUT_CYCLES  = 4096
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [ADDR_WIDTH-1:0]      S_AXI_AWADDR,
   input  logic                       S_AXI_AWVALID,
   input  logic [2:0]                 S_AXI_AWPROT,
   output logic                       S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]      S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
   input  logic                       S_AXI_WVALID,
   output logic                       S_AXI_WREADY,
   output logic [1:0]                 S_AXI_BRESP,
   output logic                       S_AXI_BVALID,
   input  logic                       S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]      S_AXI_ARADDR,
   input  logic                       S_AXI_ARVALID,
   input  logic [2:0]                 S_AXI_ARPROT,
   output logic                       S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]      S_AXI_RDATA,
   output logic [1:0]                 S_AXI_RRESP,
   output logic                       S_AXI_RVALID,
   input  logic                       S_AXI_RREADY,
   output logic [AXIS_DATA_WIDTH-1:0] AXIS_TX_TDATA,
   output logic                       AXIS_TX_TVALID,
   output logic                       AXIS_TX_TLAST,
   input  logic                       AXIS_TX_TREADY,
   input  logic [AXIS_DATA_WIDTH-1:0] AXIS_RX_TDATA,
   input  logic                       AXIS_RX_TVALID,
   input  logic                       AXIS_RX_TLAST,
   output logic                       AXIS_RX_TREADY
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_SEND  = 3'd1;
   localparam logic [2:0] c_WAIT  = 3'd2;
   localparam logic [2:0] c_BRESP = 3'd3;
   localparam logic [2:0] c_RRESP = 3'd4;

   localparam logic [31:0] c_TMO_RDATA = 32'hDEAD_DEAD;
   localparam logic [1:0]  c_SLVERR    = 2'b10;

   logic [2:0]            r_state;
   logic [2:0]            w_next_state;
   logic                  r_aw_held;
   logic                  r_w_held;
   logic                  r_prio_write;
   logic                  r_is_read;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_resp;

   logic                  w_ar_ready;
   logic                  w_ar_fire;
   logic                  w_aw_fire;
   logic                  w_w_fire;
   logic                  w_rx_match;
   logic                  w_timeout;
   logic                  w_done;
   logic [31:0]           w_exp_type;
   logic                  w_unused;

   // A pending write wins a same-cycle tie only while prio_write is set.
   assign w_ar_ready = !r_aw_held && !r_w_held &&
                       !(r_prio_write && (S_AXI_AWVALID || S_AXI_WVALID));

   assign w_aw_fire  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_w_fire   = S_AXI_WVALID  && S_AXI_WREADY;
   assign w_ar_fire  = S_AXI_ARVALID && S_AXI_ARREADY;

   assign w_exp_type = r_is_read ? PKT_TYPE_READ : PKT_TYPE_WRITE;
   assign w_rx_match = (r_state == c_WAIT) && AXIS_RX_TVALID &&
                       (AXIS_RX_TDATA[PF_TYPE +: 32] == w_exp_type);
   assign w_done     = ((r_state == c_BRESP) && S_AXI_BREADY) ||
                       ((r_state == c_RRESP) && S_AXI_RREADY);

`ifdef AOS_CLIENT_TIMEOUT_EN
   localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_TMO_W-1:0] r_timer;

   // Held at zero outside WAIT_RESP so every entry starts a fresh count.
   always_ff @(posedge clk) begin
      if (!resetn || (r_state != c_WAIT)) begin
         r_timer <= '0;
      end else if (!w_timeout) begin
         r_timer <= r_timer + c_TMO_W'(1);
      end
   end

   assign w_timeout = (r_state == c_WAIT) && !w_rx_match &&
                      (r_timer == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int c_unused_timeout = TIMEOUT_CYCLES;

   assign w_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_ar_fire || ((r_aw_held || w_aw_fire) && (r_w_held || w_w_fire))) begin
               w_next_state = c_SEND;
            end
         end
         c_SEND: begin
            if (AXIS_TX_TREADY) begin
               w_next_state = c_WAIT;
            end
         end
         c_WAIT: begin
            if (w_rx_match || w_timeout) begin
               w_next_state = r_is_read ? c_RRESP : c_BRESP;
            end
         end
         c_BRESP: begin
            if (S_AXI_BREADY) begin
               w_next_state = c_IDLE;
            end
         end
         c_RRESP: begin
            if (S_AXI_RREADY) begin
               w_next_state = c_IDLE;
            end
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   // Output logic; everything handshake-related is forced low during reset.
   always_comb begin
      S_AXI_AWREADY  = 1'b0;
      S_AXI_WREADY   = 1'b0;
      S_AXI_ARREADY  = 1'b0;
      S_AXI_BVALID   = 1'b0;
      S_AXI_RVALID   = 1'b0;
      AXIS_TX_TVALID = 1'b0;
      AXIS_RX_TREADY = 1'b0;
      if (resetn) begin
         case (r_state)
            c_IDLE: begin
               // Stale responses arriving here are drained and dropped.
               AXIS_RX_TREADY = 1'b1;
               S_AXI_ARREADY  = w_ar_ready;
               S_AXI_AWREADY  = !r_aw_held && !(w_ar_ready && S_AXI_ARVALID);
               S_AXI_WREADY   = !r_w_held  && !(w_ar_ready && S_AXI_ARVALID);
            end
            c_SEND:  AXIS_TX_TVALID = 1'b1;
            c_WAIT:  AXIS_RX_TREADY = 1'b1;
            c_BRESP: S_AXI_BVALID   = 1'b1;
            c_RRESP: S_AXI_RVALID   = 1'b1;
            default: ;
         endcase
      end
   end

   // Request capture, arbitration priority and response capture
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_aw_held    <= 1'b0;
         r_w_held     <= 1'b0;
         r_prio_write <= 1'b1;
         r_is_read    <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_resp       <= 2'b00;
      end else begin
         if (w_aw_fire) begin
            r_aw_held <= 1'b1;
            r_addr    <= S_AXI_AWADDR;
         end
         if (w_w_fire) begin
            r_w_held <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
         end
         if (w_ar_fire) begin
            r_addr <= S_AXI_ARADDR;
         end
         if ((r_state == c_IDLE) && (w_next_state == c_SEND)) begin
            r_prio_write <= !r_prio_write;
            r_is_read    <= w_ar_fire;
         end
         if (w_rx_match) begin
            r_resp <= AXIS_RX_TDATA[PF_RESP +: 2];
            if (r_is_read) begin
               r_rdata <= AXIS_RX_TDATA[PF_DATA +: DATA_WIDTH];
            end
         end else if (w_timeout) begin
            r_resp <= c_SLVERR;
            if (r_is_read) begin
               r_rdata <= DATA_WIDTH'(c_TMO_RDATA);
            end
         end
         if (w_done) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
      end
   end

   assign S_AXI_BRESP   = r_resp;
   assign S_AXI_RRESP   = r_resp;
   assign S_AXI_RDATA   = r_rdata;
   assign AXIS_TX_TLAST = AXIS_TX_TVALID;
   assign AXIS_TX_TDATA = AXIS_DATA_WIDTH'(pack_pkt(
                             r_is_read ? PKT_TYPE_READ : PKT_TYPE_WRITE,
                             64'(r_addr),
                             r_is_read ? 32'd0 : 32'(r_wdata),
                             32'd0));

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, AXIS_RX_TLAST, AXIS_RX_TDATA};

endmodule
`default_nettype wire

// File: tb/tb_aximm_over_stream_client.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_aximm_over_stream_client
// Purpose  : Scoreboard bench for aximm_over_stream_client. Directed stimulus
//            pushes expected TX beats and B/R responses into queues; a monitor
//            pops and compares whenever the DUT completes a handshake.
//            Define AOS_CLIENT_TIMEOUT_EN to also run the timeout scenario.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_aximm_over_stream_client;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [63:0]  S_AXI_AWADDR = '0;
   logic         S_AXI_AWVALID = 1'b0;
   logic         S_AXI_AWREADY;
   logic [31:0]  S_AXI_WDATA = '0;
   logic         S_AXI_WVALID = 1'b0;
   logic         S_AXI_WREADY;
   logic [1:0]   S_AXI_BRESP;
   logic         S_AXI_BVALID;
   logic         S_AXI_BREADY = 1'b1;
   logic [63:0]  S_AXI_ARADDR = '0;
   logic         S_AXI_ARVALID = 1'b0;
   logic         S_AXI_ARREADY;
   logic [31:0]  S_AXI_RDATA;
   logic [1:0]   S_AXI_RRESP;
   logic         S_AXI_RVALID;
   logic         S_AXI_RREADY = 1'b1;
   logic [255:0] AXIS_TX_TDATA;
   logic         AXIS_TX_TVALID;
   logic         AXIS_TX_TLAST;
   logic         AXIS_TX_TREADY = 1'b1;
   logic [255:0] AXIS_RX_TDATA = '0;
   logic         AXIS_RX_TVALID = 1'b0;
   logic         AXIS_RX_TREADY;

   int n_checks = 0;
   int n_fail   = 0;

   logic [255:0] exp_tx[$];
   logic [1:0]   exp_b[$];
   logic [33:0]  exp_r[$];
   logic [255:0] m_e;

   always #5 clk = ~clk;

   aximm_over_stream_client #(
      .ADDR_WIDTH      (64),
      .DATA_WIDTH      (32),
      .AXIS_DATA_WIDTH (256),
      .TIMEOUT_CYCLES  (16)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .S_AXI_AWADDR   (S_AXI_AWADDR),
      .S_AXI_AWVALID  (S_AXI_AWVALID),
      .S_AXI_AWPROT   (3'b000),
      .S_AXI_AWREADY  (S_AXI_AWREADY),
      .S_AXI_WDATA    (S_AXI_WDATA),
      .S_AXI_WSTRB    (4'hF),
      .S_AXI_WVALID   (S_AXI_WVALID),
      .S_AXI_WREADY   (S_AXI_WREADY),
      .S_AXI_BRESP    (S_AXI_BRESP),
      .S_AXI_BVALID   (S_AXI_BVALID),
      .S_AXI_BREADY   (S_AXI_BREADY),
      .S_AXI_ARADDR   (S_AXI_ARADDR),
      .S_AXI_ARVALID  (S_AXI_ARVALID),
      .S_AXI_ARPROT   (3'b000),
      .S_AXI_ARREADY  (S_AXI_ARREADY),
      .S_AXI_RDATA    (S_AXI_RDATA),
      .S_AXI_RRESP    (S_AXI_RRESP),
      .S_AXI_RVALID   (S_AXI_RVALID),
      .S_AXI_RREADY   (S_AXI_RREADY),
      .AXIS_TX_TDATA  (AXIS_TX_TDATA),
      .AXIS_TX_TVALID (AXIS_TX_TVALID),
      .AXIS_TX_TLAST  (AXIS_TX_TLAST),
      .AXIS_TX_TREADY (AXIS_TX_TREADY),
      .AXIS_RX_TDATA  (AXIS_RX_TDATA),
      .AXIS_RX_TVALID (AXIS_RX_TVALID),
      .AXIS_RX_TLAST  (1'b1),
      .AXIS_RX_TREADY (AXIS_RX_TREADY)
   );

   // Beat layout: [31:0] TYPE, [95:32] ADDR, [127:96] DATA, [159:128] RESP
   function automatic logic [255:0] pkt(input logic [31:0] t, input logic [63:0] a,
                                        input logic [31:0] d, input logic [31:0] r);
      return {96'h0, r, d, a, t};
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no event expected event within bound", name);
   endtask

   // Monitor: compare every completed handshake against the scoreboard
   always @(negedge clk) begin
      if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
         if (exp_tx.size() == 0) begin
            flag("tx_unexpected");
         end else begin
            m_e = exp_tx.pop_front();
            chk("tx_pkt", AXIS_TX_TDATA, m_e);
            chk("tx_tlast", 256'(AXIS_TX_TLAST), 256'(1));
         end
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
         if (exp_b.size() == 0) flag("b_unexpected");
         else chk("bresp", 256'(S_AXI_BRESP), 256'(exp_b.pop_front()));
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
         if (exp_r.size() == 0) flag("r_unexpected");
         else chk("rresp_rdata", 256'({S_AXI_RRESP, S_AXI_RDATA}), 256'(exp_r.pop_front()));
      end
   end

   task automatic do_aw(input logic [63:0] a);
      @(posedge clk); #1;
      S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (S_AXI_AWREADY) begin
            @(posedge clk); #1; S_AXI_AWVALID = 1'b0; return;
         end
      end
      flag("aw_handshake"); S_AXI_AWVALID = 1'b0;
   endtask

   task automatic do_w(input logic [31:0] d);
      @(posedge clk); #1;
      S_AXI_WDATA = d; S_AXI_WVALID = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (S_AXI_WREADY) begin
            @(posedge clk); #1; S_AXI_WVALID = 1'b0; return;
         end
      end
      flag("w_handshake"); S_AXI_WVALID = 1'b0;
   endtask

   task automatic do_ar(input logic [63:0] a);
      @(posedge clk); #1;
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (S_AXI_ARREADY) begin
            @(posedge clk); #1; S_AXI_ARVALID = 1'b0; return;
         end
      end
      flag("ar_handshake"); S_AXI_ARVALID = 1'b0;
   endtask

   // Returns at the negedge before the TX handshake edge
   task automatic wait_tx_hs();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (AXIS_TX_TVALID && AXIS_TX_TREADY) return;
      end
      flag("tx_wait");
   endtask

   // Returns #1 after the RX handshake edge
   task automatic send_rx(input logic [255:0] p);
      @(posedge clk); #1;
      AXIS_RX_TDATA = p; AXIS_RX_TVALID = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (AXIS_RX_TREADY) begin
            @(posedge clk); #1; AXIS_RX_TVALID = 1'b0; return;
         end
      end
      flag("rx_wait"); AXIS_RX_TVALID = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1; resetn = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_readys_low", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, AXIS_RX_TREADY}), 256'(0));
      chk("rst_valids_low", 256'({S_AXI_BVALID, S_AXI_RVALID, AXIS_TX_TVALID}), 256'(0));
      @(posedge clk); #1; resetn = 1'b1;
      @(negedge clk);
      chk("idle_readys", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, AXIS_RX_TREADY}), 256'(4'b1111));
      chk("idle_resps", 256'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_BVALID, S_AXI_RVALID, AXIS_TX_TVALID}), 256'(0));

      // ---- test 1: basic write ----
      exp_tx.push_back(pkt(32'd2, 64'h0000_0001_0000_0010, 32'hDEAD_BEEF, 32'd0));
      exp_b.push_back(2'b00);
      fork
         do_aw(64'h0000_0001_0000_0010);
         do_w(32'hDEAD_BEEF);
      join
      wait_tx_hs();
      send_rx(pkt(32'd2, 64'h0, 32'h0, 32'd0));
      chk("t1_bvalid_next_cycle", 256'(S_AXI_BVALID), 256'(1));

      // ---- test 2: W three cycles ahead of AW, then a read ----
      exp_tx.push_back(pkt(32'd2, 64'h0000_0000_0000_0020, 32'h0BAD_F00D, 32'd0));
      exp_b.push_back(2'b00);
      do_w(32'h0BAD_F00D);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t2_no_tx_before_aw", 256'(AXIS_TX_TVALID), 256'(0));
      do_aw(64'h20);
      wait_tx_hs();
      send_rx(pkt(32'd2, 64'h0, 32'h0, 32'd0));
      exp_tx.push_back(pkt(32'd1, 64'h40, 32'h0, 32'd0));
      exp_r.push_back({2'b10, 32'h1234_5678});
      do_ar(64'h40);
      wait_tx_hs();
      send_rx(pkt(32'd1, 64'h0, 32'h1234_5678, 32'd2));
      chk("t2_rvalid_next_cycle", 256'(S_AXI_RVALID), 256'(1));

      // ---- test 3: simultaneous AR/AW/W after reset -> write first ----
      do_reset();
      exp_tx.push_back(pkt(32'd2, 64'h100, 32'h1111_1111, 32'd0));
      exp_tx.push_back(pkt(32'd1, 64'h200, 32'h0, 32'd0));
      exp_b.push_back(2'b00);
      exp_r.push_back({2'b00, 32'hAAAA_0001});
      fork
         do_aw(64'h100);
         do_w(32'h1111_1111);
         do_ar(64'h200);
      join_none
      wait_tx_hs();
      send_rx(pkt(32'd2, 64'h0, 32'h0, 32'd0));
      wait_tx_hs();
      send_rx(pkt(32'd1, 64'h0, 32'hAAAA_0001, 32'd0));
      repeat (3) @(posedge clk);
      // Two grants since reset leave priority with writes; one lone write
      // hands it to reads so the next tie must go read-first.
      exp_tx.push_back(pkt(32'd2, 64'h300, 32'h3333_3333, 32'd0));
      exp_b.push_back(2'b00);
      fork
         do_aw(64'h300);
         do_w(32'h3333_3333);
      join
      wait_tx_hs();
      send_rx(pkt(32'd2, 64'h0, 32'h0, 32'd0));
      exp_tx.push_back(pkt(32'd1, 64'h400, 32'h0, 32'd0));
      exp_tx.push_back(pkt(32'd2, 64'h500, 32'h2222_2222, 32'd0));
      exp_r.push_back({2'b00, 32'hBBBB_0002});
      exp_b.push_back(2'b00);
      fork
         do_aw(64'h500);
         do_w(32'h2222_2222);
         do_ar(64'h400);
      join_none
      wait_tx_hs();
      send_rx(pkt(32'd1, 64'h0, 32'hBBBB_0002, 32'd0));
      wait_tx_hs();
      send_rx(pkt(32'd2, 64'h0, 32'h0, 32'd0));
      repeat (3) @(posedge clk);

      // ---- test 4: TX backpressure and mismatched response ----
      AXIS_TX_TREADY = 1'b0;
      exp_tx.push_back(pkt(32'd2, 64'h600, 32'hCAFE_F00D, 32'd0));
      exp_b.push_back(2'b01);
      fork
         do_aw(64'h600);
         do_w(32'hCAFE_F00D);
      join
      n = 0;
      while (!AXIS_TX_TVALID && n < 50) begin
         @(negedge clk); n++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("t4_tvalid_hold", 256'(AXIS_TX_TVALID), 256'(1));
         chk("t4_tdata_hold", AXIS_TX_TDATA, pkt(32'd2, 64'h600, 32'hCAFE_F00D, 32'd0));
         @(negedge clk);
      end
      @(posedge clk); #1; AXIS_TX_TREADY = 1'b1;
      wait_tx_hs();
      send_rx(pkt(32'd1, 64'h0, 32'h5555_5555, 32'd3));
      repeat (3) begin
         @(negedge clk);
         chk("t4_drop_no_bvalid", 256'({S_AXI_BVALID, S_AXI_RVALID}), 256'(0));
      end
      send_rx(pkt(32'd2, 64'h0, 32'h0, 32'd1));
      repeat (3) @(posedge clk);

      // ---- test 5a: reset while waiting for the response ----
      exp_tx.push_back(pkt(32'd2, 64'h700, 32'h7777_7777, 32'd0));
      fork
         do_aw(64'h700);
         do_w(32'h7777_7777);
      join
      wait_tx_hs();
      @(posedge clk); #1; resetn = 1'b0;
      @(negedge clk);
      chk("t5_reset_outputs", 256'({S_AXI_AWREADY, AXIS_RX_TREADY, S_AXI_BVALID, AXIS_TX_TVALID}), 256'(0));
      @(posedge clk); #1; resetn = 1'b1;
      send_rx(pkt(32'd2, 64'h0, 32'h0, 32'd1));
      repeat (4) begin
         @(negedge clk);
         chk("t5_late_drained", 256'({S_AXI_BVALID, S_AXI_RVALID}), 256'(0));
      end

      // ---- test 5b: reset drops a TX beat in flight ----
      AXIS_TX_TREADY = 1'b0;
      fork
         do_aw(64'h800);
         do_w(32'h8888_8888);
      join
      n = 0;
      while (!AXIS_TX_TVALID && n < 50) begin
         @(negedge clk); n++;
      end
      chk("t5b_tvalid_before_reset", 256'(AXIS_TX_TVALID), 256'(1));
      @(posedge clk); #1; resetn = 1'b0;
      @(posedge clk); #1; resetn = 1'b1; AXIS_TX_TREADY = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t5b_tx_dropped", 256'({AXIS_TX_TVALID, S_AXI_BVALID}), 256'(0));
      end

`ifdef AOS_CLIENT_TIMEOUT_EN
      // ---- test 6: read with no response times out ----
      exp_tx.push_back(pkt(32'd1, 64'h80, 32'h0, 32'd0));
      exp_r.push_back({2'b10, 32'hDEAD_DEAD});
      do_ar(64'h80);
      wait_tx_hs();
      @(posedge clk);
      n = 0;
      while (n < 100) begin
         @(posedge clk); #1; n++;
         if (S_AXI_RVALID) break;
      end
      chk("t6_timeout_latency", 256'(n), 256'(16));
      repeat (3) @(posedge clk);
`endif

      repeat (5) @(posedge clk);
      chk("left_tx", 256'(exp_tx.size()), 256'(0));
      chk("left_b", 256'(exp_b.size()), 256'(0));
      chk("left_r", 256'(exp_r.size()), 256'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
